// File: rtl/down_counter.sv
// Loadable down-counter / countdown timer with a prescaled tick, a one-cycle
// done pulse at terminal count and optional auto-reload.
module down_counter #(
    parameter int unsigned BW          = 4,
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [BW-1:0] loadVal_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          en_i,
    output logic [BW-1:0] count_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_count;
    logic [BW-1:0] r_reload;
    logic [PW-1:0] r_pre;
    logic          r_busy;
    logic          r_done;
    logic          w_tick;

    assign w_tick  = en_i && (r_pre == PRE_MAX);
    assign count_o = r_count;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

    // Priority per edge: clear > load > stop > start > tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_pre    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (clr_i) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_pre    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load_i) begin
                r_count  <= loadVal_i;
                r_reload <= loadVal_i;
                r_pre    <= '0;
                if ((r_state == S_RUN) && (loadVal_i == '0)) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            end else if (stop_i) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else if (r_state == S_IDLE) begin
                if (start_i) begin
                    r_pre <= '0;
                    if (r_count != '0) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else if (en_i) begin
                // Prescaler only advances while running; start in RUN falls through here.
                if (w_tick) begin
                    r_pre <= '0;
                    if (r_count > BW'(1)) begin
                        r_count <= r_count - BW'(1);
                    end else if (r_count == BW'(1)) begin
                        r_done <= 1'b1;
                        if ((AUTO_RELOAD != 0) && (r_reload != '0)) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: three configurations share one stimulus stream and are
// checked every cycle against a behavioural model plus literal expectations.
module tb_down_counter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       load_i = 1'b0;
    logic [3:0] loadVal_i = 4'd0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       en_i = 1'b1;

    logic [3:0] cnt0, cnt1, cnt2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    // 0: PRESCALE=1 one-shot, 1: PRESCALE=3 one-shot, 2: PRESCALE=1 auto-reload
    down_counter #(.BW(4), .PRESCALE(1), .AUTO_RELOAD(0)) u_p1 (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .load_i(load_i),
        .loadVal_i(loadVal_i), .start_i(start_i), .stop_i(stop_i), .en_i(en_i),
        .count_o(cnt0), .busy_o(busy0), .done_o(done0));
    down_counter #(.BW(4), .PRESCALE(3), .AUTO_RELOAD(0)) u_p3 (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .load_i(load_i),
        .loadVal_i(loadVal_i), .start_i(start_i), .stop_i(stop_i), .en_i(en_i),
        .count_o(cnt1), .busy_o(busy1), .done_o(done1));
    down_counter #(.BW(4), .PRESCALE(1), .AUTO_RELOAD(1)) u_ar (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .load_i(load_i),
        .loadVal_i(loadVal_i), .start_i(start_i), .stop_i(stop_i), .en_i(en_i),
        .count_o(cnt2), .busy_o(busy2), .done_o(done2));

    localparam int PS [3] = '{1, 3, 1};
    localparam int AR [3] = '{0, 0, 1};

    int m_cnt [3];
    int m_rel [3];
    int m_pre [3];
    bit m_run [3];
    bit m_done[3];
    bit m_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_pre[k] = 0; m_run[k] = 0; m_done[k] = 0;
        end
    endtask

    // One clock edge of the timer, in plain integer terms.
    task automatic model_step(input int k);
        m_done[k] = 0;
        if (clr_i) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_pre[k] = 0; m_run[k] = 0;
        end else if (load_i) begin
            m_cnt[k] = int'(loadVal_i);
            m_rel[k] = int'(loadVal_i);
            m_pre[k] = 0;
            if (m_cnt[k] == 0) m_run[k] = 0;
        end else if (stop_i) begin
            m_run[k] = 0;
        end else if (!m_run[k]) begin
            if (start_i) begin
                m_pre[k] = 0;
                if (m_cnt[k] != 0) m_run[k] = 1;
                else m_done[k] = 1;
            end
        end else if (en_i) begin
            m_pre[k] = (m_pre[k] + 1) % PS[k];
            if (m_pre[k] == 0) begin
                if (m_cnt[k] > 1) begin
                    m_cnt[k] = m_cnt[k] - 1;
                end else if (m_cnt[k] == 1) begin
                    m_done[k] = 1;
                    m_cnt[k] = (AR[k] != 0) ? m_rel[k] : 0;
                    if (m_cnt[k] == 0) m_run[k] = 0;
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    endtask

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            model_reset();
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    always @(negedge clk_i) begin
        if (m_valid) begin
            check("p1_count", int'(cnt0), m_cnt[0]);
            check("p1_busy",  int'(busy0), int'(m_run[0]));
            check("p1_done",  int'(done0), int'(m_done[0]));
            check("p3_count", int'(cnt1), m_cnt[1]);
            check("p3_busy",  int'(busy1), int'(m_run[1]));
            check("p3_done",  int'(done1), int'(m_done[1]));
            check("ar_count", int'(cnt2), m_cnt[2]);
            check("ar_busy",  int'(busy2), int'(m_run[2]));
            check("ar_done",  int'(done2), int'(m_done[2]));
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input int v);
        loadVal_i = 4'(v);
        load_i = 1'b1;
        cyc();
        load_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic do_stop();
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
    endtask

    int exp_ar_cnt [6] = '{2, 1, 3, 2, 1, 3};
    int exp_ar_done[6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        #1 rst_i = 1'b1;
        #1;
        check("rst_p1_count", int'(cnt0), 0);
        check("rst_p1_busy", int'(busy0), 0);
        check("rst_ar_done", int'(done2), 0);
        #1 rst_i = 1'b0;

        // Plain countdown 5..0
        do_load(5);
        check("t1_loaded", int'(cnt0), 5);
        check("t1_idle", int'(busy0), 0);
        do_start();
        check("t1_busy", int'(busy0), 1);
        check("t1_start_cnt", int'(cnt0), 5);
        for (int i = 4; i >= 0; i--) begin
            cyc();
            check("t1_cnt", int'(cnt0), i);
            check("t1_done", int'(done0), (i == 0) ? 1 : 0);
            check("t1_busy_run", int'(busy0), (i != 0) ? 1 : 0);
        end
        cyc();
        check("t1_done_once", int'(done0), 0);
        check("t1_busy_end", int'(busy0), 0);
        do_stop();

        // Prescale by 3
        do_load(2);
        do_start();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check("t2_cnt", int'(cnt1), (k < 3) ? 2 : (k < 6) ? 1 : 0);
            check("t2_done", int'(done1), (k == 6) ? 1 : 0);
            check("t2_busy", int'(busy1), (k < 6) ? 1 : 0);
        end
        do_stop();

        // Enable gap keeps prescaler phase
        do_load(4);
        do_start();
        repeat (4) cyc();
        check("t3_cnt3", int'(cnt1), 3);
        en_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t3_hold", int'(cnt1), 3);
            check("t3_hold_busy", int'(busy1), 1);
        end
        en_i = 1'b1;
        cyc();
        check("t3_resume1", int'(cnt1), 3);
        cyc();
        check("t3_resume2", int'(cnt1), 2);
        do_stop();

        // Auto-reload period 3
        do_load(3);
        do_start();
        check("t4_start", int'(cnt2), 3);
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("t4_cnt", int'(cnt2), exp_ar_cnt[k]);
            check("t4_done", int'(done2), exp_ar_done[k]);
            check("t4_busy", int'(busy2), 1);
        end
        do_stop();
        check("t4_stopped", int'(busy2), 0);

        // Start at zero, load zero while running, stop mid-count
        do_load(0);
        do_start();
        check("t5_zero_done", int'(done0), 1);
        check("t5_zero_busy", int'(busy0), 0);
        cyc();
        check("t5_zero_done_pulse", int'(done0), 0);
        do_load(5);
        do_start();
        cyc();
        check("t5_run_cnt", int'(cnt0), 4);
        do_load(0);
        check("t5_load0_busy", int'(busy0), 0);
        check("t5_load0_cnt", int'(cnt0), 0);
        check("t5_load0_done", int'(done0), 0);
        cyc();
        check("t5_load0_done2", int'(done0), 0);
        do_load(4);
        do_start();
        cyc();
        cyc();
        check("t5_cnt2", int'(cnt0), 2);
        do_stop();
        check("t5_stop_cnt", int'(cnt0), 2);
        check("t5_stop_busy", int'(busy0), 0);
        check("t5_stop_done", int'(done0), 0);
        cyc();
        cyc();
        check("t5_stop_hold", int'(cnt0), 2);

        // Async reset mid-run, then clear beats load
        do_load(6);
        do_start();
        cyc();
        cyc();
        check("t6_cnt4", int'(cnt0), 4);
        #2 rst_i = 1'b1;
        #1;
        check("t6_rst_cnt", int'(cnt0), 0);
        check("t6_rst_busy", int'(busy0), 0);
        check("t6_rst_done", int'(done0), 0);
        #1 rst_i = 1'b0;
        do_load(7);
        do_start();
        check("t6_run_again", int'(busy0), 1);
        clr_i = 1'b1;
        do_load(9);
        clr_i = 1'b0;
        check("t6_clr_cnt", int'(cnt0), 0);
        check("t6_clr_busy", int'(busy0), 0);
        check("t6_clr_p3_cnt", int'(cnt1), 0);
        do_start();
        check("t6_clr_reload_done", int'(done0), 1);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
